junction_phase_scheduler: RTL and testbench

- Sequences the FF, BP and UP processor sets of one junction for one training sample.
- Generates:
  - the shared cycle index used to address the weight, bias, activation and delta memories;
  - per-phase enables and the FF output-valid strobe, which accounts for the 1-cycle sigmoid table latency;
  - the learning-rate shift (etapos) consumed by the UP set.
- Sits between the network-level sample controller (start/done handshake) and the junction datapath.

---
 rtl/junction_phase_scheduler_if.sv | 22 ++
 rtl/junction_phase_scheduler.sv | 134 +++++++++++++
 tb/tb_junction_phase_scheduler.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/junction_phase_scheduler_if.sv
// Sample-level start/done handshake between the network controller
// and one junction's phase scheduler.
interface junction_phase_scheduler_if;
   logic start;
   logic train;
   logic ready;
   logic done;

   modport master (
      output start,
      output train,
      input  ready,
      input  done
   );

   modport slave (
      input  start,
      input  train,
      output ready,
      output done
   );
endinterface

// File: rtl/junction_phase_scheduler.sv
// Sequences FF, drain, BP/UP and done phases of one junction per sample,
// and tracks the decaying learning-rate shift for the UP set.
module junction_phase_scheduler #(
   parameter int fo        = 2,
   parameter int fi        = 4,
   parameter int p         = 16,
   parameter int z         = 8,
   parameter int frac_bits = 10,
   parameter int cpc       = p * fo / z,
   parameter int ci_w      = $clog2(cpc),
   parameter int ep_w      = $clog2(frac_bits + 2)
) (
   input  logic                clk,
   input  logic                reset_n,
   junction_phase_scheduler_if.slave ctl,
   input  logic                pause,
   input  logic                eta_load,
   input  logic [ep_w-1:0]     etapos_init,
   input  logic [15:0]         decay_period,
   output logic [ci_w-1:0]     cycle_index,
   output logic                ff_en,
   output logic                act_valid,
   output logic                bp_en,
   output logic                up_en,
   output logic [ep_w-1:0]     etapos
);

   if (cpc < 2 || fi < 1) begin : g_cfg_err
      $error("junction_phase_scheduler: cpc must be >= 2");
   end

   typedef enum logic [2:0] {
      IDLE, FF, DRAIN, BPUP, DONE
   } state_t;

   localparam logic [ci_w-1:0] last = ci_w'(cpc - 1);
   localparam logic [ep_w-1:0] emax = ep_w'(frac_bits + 1);

   state_t          state, ns;
   logic [ci_w-1:0] cnt, ncnt;
   logic            train_q;
   logic            ff_d, bp_d, done_d;
   logic [15:0]     scnt;

   // cnt is the pending index; it only advances after an enabled cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         cnt       <= '0;
         train_q   <= 1'b0;
         ff_en     <= 1'b0;
         bp_en     <= 1'b0;
         act_valid <= 1'b0;
         ctl.done  <= 1'b0;
      end else begin
         state     <= ns;
         cnt       <= ncnt;
         ff_en     <= ff_d;
         bp_en     <= bp_d;
         act_valid <= ff_en;
         ctl.done  <= done_d;
         if (state == IDLE && ctl.start)
            train_q <= ctl.train;
      end
   end

   always_comb begin
      ns   = state;
      ncnt = cnt;
      unique case (state)
         IDLE: begin
            if (ctl.start) begin
               ns   = FF;
               ncnt = '0;
            end
         end
         FF: begin
            if (ff_en && cnt == last) begin
               ns   = DRAIN;
               ncnt = '0;
            end else begin
               ncnt = cnt + ci_w'(ff_en);
            end
         end
         DRAIN: begin
            ns = train_q ? BPUP : DONE;
         end
         BPUP: begin
            if (bp_en && cnt == last) begin
               ns   = DONE;
               ncnt = '0;
            end else begin
               ncnt = cnt + ci_w'(bp_en);
            end
         end
         DONE: begin
            ns = IDLE;
         end
         default: begin
            ns   = IDLE;
            ncnt = '0;
         end
      endcase
   end

   // pause blocks the next issue only while staying inside a phase
   always_comb begin
      ff_d   = (ns == FF) && !(state == FF && pause);
      bp_d   = (ns == BPUP) && !(state == BPUP && pause);
      done_d = (ns == DONE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         etapos <= '0;
         scnt   <= '0;
      end else if (state == IDLE) begin
         if (eta_load)
            etapos <= (etapos_init > emax) ? emax : etapos_init;
      end else if (state == DONE && train_q && decay_period != 16'd0) begin
         if (scnt >= decay_period - 16'd1) begin
            scnt   <= '0;
            etapos <= (etapos < emax) ? etapos + 1'b1 : emax;
         end else begin
            scnt <= scnt + 16'd1;
         end
      end
   end

   assign ctl.ready   = (state == IDLE);
   assign cycle_index = cnt;
   assign up_en       = bp_en;

endmodule

// File: tb/tb_junction_phase_scheduler.sv
// Directed bench for junction_phase_scheduler: phase timing, pause,
// learning-rate decay, asynchronous reset and back-to-back samples.
module tb_junction_phase_scheduler;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   junction_phase_scheduler_if ctl ();

   logic        pause = 1'b0;
   logic        eta_load = 1'b0;
   logic [3:0]  etapos_init = '0;
   logic [15:0] decay_period = '0;
   logic [1:0]  cycle_index;
   logic        ff_en, act_valid, bp_en, up_en;
   logic [3:0]  etapos;

   junction_phase_scheduler dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .ctl          (ctl),
      .pause        (pause),
      .eta_load     (eta_load),
      .etapos_init  (etapos_init),
      .decay_period (decay_period),
      .cycle_index  (cycle_index),
      .ff_en        (ff_en),
      .act_valid    (act_valid),
      .bp_en        (bp_en),
      .up_en        (up_en),
      .etapos       (etapos)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   typedef struct {
      bit tr;
      int ps;
      int pl;
      int done_c;
      int ff_c;
      int bp_c;
   } vec_t;

   vec_t vecs[7];

   // Starts one sample on the current negedge and observes it cycle by cycle.
   task automatic run_sample(
      input  bit tr, input int ps, input int pl,
      output int dcyc, output int ffc, output int bpc,
      output int avc, output int serr, output int ep_done);
      int  ffn, bpn, w;
      bit  prev_ff;
      dcyc = -1; ffc = 0; bpc = 0; avc = 0;
      serr = 0; ep_done = -1; ffn = 0; bpn = 0;
      w = 0;
      while (!ctl.ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      ctl.start = 1'b1;
      ctl.train = tr;
      prev_ff = ff_en;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         ctl.start = 1'b0;
         pause = (pl > 0 && c >= ps && c < ps + pl);
         if (act_valid !== prev_ff) serr++;
         prev_ff = ff_en;
         if (up_en !== bp_en) serr++;
         if (ff_en && bp_en) serr++;
         if (ff_en) begin
            if (cycle_index !== ffn[1:0]) serr++;
            ffn++;
            ffc++;
         end
         if (bp_en) begin
            if (cycle_index !== bpn[1:0]) serr++;
            bpn++;
            bpc++;
         end
         if (act_valid) avc++;
         if (ctl.done) begin
            if (dcyc >= 0 || ctl.ready) serr++;
            dcyc = c;
            ep_done = int'(etapos);
         end else if (dcyc < 0 && ctl.ready) begin
            serr++;
         end
         if (dcyc > 0 && c == dcyc + 1) begin
            if (!ctl.ready) serr++;
            break;
         end
      end
      pause = 1'b0;
   endtask

   task automatic run_checked(input string name, input bit tr,
                              input int exp_done, output int ep_done);
      int d, f, b, a, s;
      run_sample(tr, 0, 0, d, f, b, a, s, ep_done);
      check({name, "_done_cycle"}, d, exp_done);
      check({name, "_struct"}, s, 0);
   endtask

   task automatic load_eta(input logic [3:0] v);
      eta_load    = 1'b1;
      etapos_init = v;
      @(negedge clk);
      eta_load = 1'b0;
   endtask

   initial begin
      int d, f, b, a, s, e;
      int exp_ep[5];
      int dones, ffs, first_ff, w;

      vecs[0] = '{1'b1, 0, 0, 10, 4, 4};
      vecs[1] = '{1'b0, 0, 0,  6, 4, 0};
      vecs[2] = '{1'b1, 2, 2, 12, 4, 4};
      vecs[3] = '{1'b1, 7, 1, 11, 4, 4};
      vecs[4] = '{1'b0, 1, 3,  9, 4, 0};
      vecs[5] = '{1'b1, 4, 2, 10, 4, 4};
      vecs[6] = '{1'b1, 9, 1, 10, 4, 4};
      exp_ep[0] = 3; exp_ep[1] = 3; exp_ep[2] = 4;
      exp_ep[3] = 4; exp_ep[4] = 5;

      ctl.start = 1'b0;
      ctl.train = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ready", int'(ctl.ready), 1);
      check("rst_ff_en", int'(ff_en), 0);
      check("rst_bp_en", int'(bp_en), 0);
      check("rst_act_valid", int'(act_valid), 0);
      check("rst_done", int'(ctl.done), 0);
      check("rst_etapos", int'(etapos), 0);
      check("rst_index", int'(cycle_index), 0);
      reset_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         run_sample(vecs[i].tr, vecs[i].ps, vecs[i].pl, d, f, b, a, s, e);
         check($sformatf("v%0d_done_cycle", i), d, vecs[i].done_c);
         check($sformatf("v%0d_ff_count", i), f, vecs[i].ff_c);
         check($sformatf("v%0d_bp_count", i), b, vecs[i].bp_c);
         check($sformatf("v%0d_act_count", i), a, 4);
         check($sformatf("v%0d_struct", i), s, 0);
      end
      check("no_decay_etapos", int'(etapos), 0);

      decay_period = 16'd2;
      load_eta(4'd3);
      check("eta_load_3", int'(etapos), 3);
      for (int i = 0; i < 5; i++) begin
         run_checked($sformatf("decay%0d", i), 1'b1, 10, e);
         check($sformatf("decay%0d_etapos", i), e, exp_ep[i]);
      end
      check("decay_after5", int'(etapos), 5);

      run_checked("inf_a", 1'b0, 6, e);
      run_checked("inf_b", 1'b0, 6, e);
      check("inference_no_count", int'(etapos), 5);

      decay_period = 16'd1;
      run_checked("period_shrink", 1'b1, 10, e);
      check("period_shrink_etapos", int'(etapos), 6);

      load_eta(4'd15);
      check("eta_load_sat", int'(etapos), 11);
      run_checked("sat_train", 1'b1, 10, e);
      check("decay_sat", int'(etapos), 11);

      decay_period = 16'd0;
      load_eta(4'd4);
      run_checked("period0", 1'b1, 10, e);
      check("period0_etapos", int'(etapos), 4);

      ctl.start = 1'b1;
      ctl.train = 1'b1;
      @(negedge clk);
      ctl.start = 1'b0;
      repeat (6) @(negedge clk);
      check("mid_bpup_bp_en", int'(bp_en), 1);
      #1 reset_n = 1'b0;
      #1;
      check("arst_bp_en", int'(bp_en), 0);
      check("arst_up_en", int'(up_en), 0);
      check("arst_ready", int'(ctl.ready), 1);
      check("arst_etapos", int'(etapos), 0);
      check("arst_index", int'(cycle_index), 0);
      check("arst_done", int'(ctl.done), 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      run_sample(1'b1, 0, 0, d, f, b, a, s, e);
      check("post_rst_done_cycle", d, 10);
      check("post_rst_ff_count", f, 4);
      check("post_rst_struct", s, 0);

      dones = 0; ffs = 0; first_ff = -1;
      ctl.start = 1'b1;
      ctl.train = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (ctl.done) dones++;
         if (ff_en) ffs++;
         if (ff_en && dones == 1 && first_ff < 0) first_ff = c;
      end
      ctl.start = 1'b0;
      check("b2b_dones", dones, 2);
      check("b2b_ff_cycles", ffs, 12);
      check("b2b_first_ff_after_done", first_ff, 12);
      w = 0;
      while (!(ctl.ready && !ctl.done) && w < 40) begin
         @(negedge clk);
         w++;
      end
      check("b2b_returns_idle", int'(ctl.ready), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
